// File: rtl/hl_mem_port.sv
// (HL) operand memory port: one byte read/write at H:L over a req/ack bus with a watchdog abort.
// Optional HL post-increment/decrement write-back is built when HL_POSTINC_EN is defined.
module hl_mem_port #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic        op_write_i,
  input  logic [7:0]  op_data_i,
  input  logic [1:0]  op_incdec_i,
  input  logic [15:0] hl_addr_i,
  output logic [7:0]  rd_data_o,
  output logic        rd_valid_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i,
  output logic [15:0] hl_next_o,
  output logic        hl_update_o
);

  // state  | meaning
  // S_IDLE | ready for a new (HL) op
  // S_BUS  | strobe asserted, waiting for mem_ack or watchdog
  // S_RESP | single-cycle completion: done/rd_valid/err/hl_update
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [15:0]          addr_q;
  logic [7:0]           wdata_q;
  logic                 write_q;
  logic                 err_q;
  logic [7:0]           rd_data_q;
  logic [TIMEOUT_W-1:0] wdog_q;
  logic                 accept;
  logic                 timeout_hit;

  assign accept      = op_valid_i && (state_q == S_IDLE);
  // An ack on the final watchdog cycle takes priority over the abort.
  assign timeout_hit = (state_q == S_BUS) && !mem_ack_i &&
                       (wdog_q == TIMEOUT_W'(TIMEOUT - 1));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (op_valid_i) state_d = S_BUS;
      S_BUS:   if (mem_ack_i || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      wdog_q    <= '0;
    end else if (accept) begin
      addr_q  <= hl_addr_i;
      wdata_q <= op_data_i;
      write_q <= op_write_i;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else if (state_q == S_BUS) begin
      if (mem_ack_i) begin
        if (!write_q) rd_data_q <= mem_rdata_i;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
        if (!write_q) rd_data_q <= 8'hFF;
      end else begin
        wdog_q <= wdog_q + TIMEOUT_W'(1);
      end
    end
  end

`ifdef HL_POSTINC_EN
  logic [1:0]  incdec_q;
  logic [15:0] hl_calc;
  logic        hl_step;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      incdec_q <= 2'b00;
    end else if (accept) begin
      incdec_q <= op_incdec_i;
    end
  end

  always_comb begin
    hl_calc = addr_q;
    hl_step = 1'b0;
    case (incdec_q)
      2'b01: begin hl_calc = addr_q + 16'd1; hl_step = 1'b1; end
      2'b10: begin hl_calc = addr_q - 16'd1; hl_step = 1'b1; end
      default: ;
    endcase
  end
`else
  logic [15:0] hl_calc;
  logic        hl_step;
  logic        unused_incdec;

  assign hl_calc       = 16'h0000;
  assign hl_step       = 1'b0;
  assign unused_incdec = ^op_incdec_i;
`endif

  always_comb begin
    op_ready_o  = 1'b0;
    busy_o      = 1'b0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    done_o      = 1'b0;
    rd_valid_o  = 1'b0;
    err_o       = 1'b0;
    hl_next_o   = 16'h0000;
    hl_update_o = 1'b0;
    case (state_q)
      S_IDLE: op_ready_o = 1'b1;
      S_BUS: begin
        busy_o   = 1'b1;
        mem_rd_o = !write_q;
        mem_wr_o = write_q;
      end
      S_RESP: begin
        busy_o      = 1'b1;
        done_o      = 1'b1;
        rd_valid_o  = !write_q && !err_q;
        err_o       = err_q;
        hl_next_o   = hl_calc;
        hl_update_o = hl_step && !err_q;
      end
      default: ;
    endcase
  end

  assign rd_data_o   = rd_data_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule
